conv_ctrl: RTL
==============

CONV_CTRL -- requirements
Module: conv_ctrl

Interface
REQ-001 Parameter WIN_OFFSET, default 0: cycles from conv_start rise to win_start rise (0..15).
REQ-002 Parameter TIMEOUT, default 1023: max cycles in RUN before watchdog error.
REQ-003 clk  input  1  clock, rising-edge.
REQ-004 rstn  input  1  reset, asynchronous, active-low.
REQ-005 cmd_valid  input  1  layer job request.
REQ-006 cmd_ready  output  1  high only in IDLE.
REQ-007 cmd_layer  input  1  0 = 28x28 input layer, 1 = 12x12 input layer.
REQ-008 cmd_nch  input  8  output channels to process.
REQ-009 rom_addr  output  13  weight ROM bit address; ROM returns data 1 cycle later.
REQ-010 rom_rdata  input  1  weight bit from ROM.
REQ-011 conv_start  output  1  conv engine run enable.
REQ-012 conv_weight  output  1  weight bit to engine.
REQ-013 conv_weight_en  output  1  weight bit valid.
REQ-014 conv_state  output  1  latched cmd_layer.
REQ-015 win_start  output  1  sliding-window run enable.
REQ-016 conv_ovalid  input  1  engine output-valid pulse.
REQ-017 conv_done  input  1  engine channel-complete pulse.
REQ-018 ch_idx  output  8  current channel.
REQ-019 busy  output  1  high outside IDLE.
REQ-020 done  output  1  one-cycle pulse at job end.
REQ-021 err  output  1  sticky error; cleared on next accepted command.

Function
REQ-022 FSM states IDLE, PREF, RUN, GAP; command accepted on cmd_valid && cmd_ready; cmd_layer and cmd_nch latched on accept.
REQ-023 Accept with cmd_nch = 0 -> no engine activity; done pulses the cycle after accept; stays IDLE.
REQ-024 IDLE->PREF on accept (nch>0); ch_idx = 0; PREF lasts exactly 1 cycle with rom_addr = ch_idx*25.
REQ-025 PREF->RUN; conv_start high for whole RUN state; weight counter w = 0 on RUN entry.
REQ-026 RUN, w<25: conv_weight = rom_rdata, conv_weight_en = 1, rom_addr = ch_idx*25 + w + 1, w increments; bit n reaches engine in RUN cycle n.
REQ-027 RUN, w = 25: conv_weight_en = 0, w holds, rom_addr holds.
REQ-028 win_start rises WIN_OFFSET cycles after RUN entry, falls with conv_start.
REQ-029 Output counter counts conv_ovalid pulses in RUN; cleared on RUN entry.
REQ-030 conv_done in RUN -> GAP; err set if count != 576 (layer 0) or 64 (layer 1).
REQ-031 RUN cycle count reaching TIMEOUT without conv_done -> err set, job aborted to IDLE, done pulses.
REQ-032 GAP: conv_start = win_start = 0 for exactly 1 cycle (engine counter reset).
REQ-033 GAP -> PREF with ch_idx+1 if ch_idx+1 < nch; else -> IDLE with done pulse.
REQ-034 conv_done or conv_ovalid outside RUN ignored; cmd_valid while busy ignored (not queued).
REQ-035 Address arithmetic unsigned 13-bit; max 254*25+25 = 6375, no wrap.

Reset
REQ-036 rstn low, any state -> IDLE immediately; all outputs 0 except cmd_ready = 1; counters and latched command cleared.
REQ-037 Reset mid-job discards the job; no done pulse.

Structure
REQ-038 Shared package conv_pkg: K = 5, KK = 25, layer output counts 576/64, FSM state encoding.
REQ-039 One sub-module natural: conv_ctrl_wdog (RUN cycle counter with TIMEOUT compare); else flat.

Verification
REQ-040 Layer 0, nch = 1, engine model emits 576 ovalid then done -> rom_addr 0..25 sequence, 25 weight_en cycles, done once, err = 0.
REQ-041 Layer 1, nch = 3 -> ch_idx 0,1,2; rom_addr bases 0, 25, 50; 1-cycle GAP with conv_start low between channels; one done.
REQ-042 nch = 0 -> done next cycle, conv_start never high.
REQ-043 Layer 1, model emits 63 ovalid -> err = 1 after conv_done; job continues; err cleared by next accept.
REQ-044 Engine never sends done, TIMEOUT = 100 -> err = 1 and done at RUN cycle 100, then IDLE.
REQ-045 rstn low during RUN of channel 2 -> outputs 0 and cmd_ready = 1 at once; no done; new command accepted after release.

Source files
------------

// File: rtl/conv_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// conv_pkg : shared constants, state encoding and helpers for conv_ctrl
// Rev 1.0
// ----------------------------------------------------------------------------
package conv_pkg;

  localparam int K  = 5;
  localparam int KK = K * K;

  localparam logic [9:0] OUT_CNT_L0 = 10'd576;  // 24x24 outputs from a 28x28 input
  localparam logic [9:0] OUT_CNT_L1 = 10'd64;   // 8x8 outputs from a 12x12 input

  typedef logic [7:0] nch_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PREF = 2'd1,
    ST_RUN  = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

  function automatic logic [12:0] ch_base(input logic [7:0] ch);
    return {5'd0, ch} * 13'(KK);
  endfunction

  function automatic logic [9:0] exp_outs(input logic layer);
    return layer ? OUT_CNT_L1 : OUT_CNT_L0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/conv_ctrl_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// conv_ctrl_if : layer job command handshake
// Rev 1.0
// ----------------------------------------------------------------------------
interface conv_ctrl_if;

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_layer;
  conv_pkg::nch_t    cmd_nch;

  modport master (output cmd_valid, output cmd_layer, output cmd_nch, input  cmd_ready);
  modport slave  (input  cmd_valid, input  cmd_layer, input  cmd_nch, output cmd_ready);

endinterface
`default_nettype wire

// File: rtl/conv_ctrl_wdog.sv
`default_nettype none
// ----------------------------------------------------------------------------
// conv_ctrl_wdog : counts cycles spent in RUN and flags the last allowed one
// Rev 1.0
// ----------------------------------------------------------------------------
module conv_ctrl_wdog #(
  parameter int TIMEOUT = 1023
) (
  input  logic clk,
  input  logic rstn,
  input  logic i_run,
  output logic o_expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = i_run ? cnt_q + 1'b1 : '0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  // Fires in the TIMEOUT-th RUN cycle so RUN never exceeds TIMEOUT cycles.
  assign o_expired = i_run && (cnt_q == CW'(TIMEOUT - 1));

endmodule
`default_nettype wire

// File: rtl/conv_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// conv_ctrl : per-channel sequencer feeding weights and run enables to the conv engine
// Rev 1.0
// ----------------------------------------------------------------------------
module conv_ctrl
  import conv_pkg::*;
#(
  parameter int WIN_OFFSET = 0,
  parameter int TIMEOUT    = 1023
) (
  input  logic              clk,
  input  logic              rstn,
  conv_ctrl_if.slave        cmd,
  output logic [12:0]       rom_addr,
  input  logic              rom_rdata,
  output logic              conv_start,
  output logic              conv_weight,
  output logic              conv_weight_en,
  output logic              conv_state,
  output logic              win_start,
  input  logic              conv_ovalid,
  input  logic              conv_done,
  output logic [7:0]        ch_idx,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [3:0] WOFF = 4'(WIN_OFFSET);

  state_t      state_q, state_d;
  logic        layer_q, layer_d;
  logic [7:0]  nch_q,   nch_d;
  logic [7:0]  ch_q,    ch_d;
  logic [4:0]  w_q,     w_d;
  logic [9:0]  oc_q,    oc_d;
  logic [3:0]  win_q,   win_d;
  logic        done_q,  done_d;
  logic        err_q,   err_d;

  logic        in_run;
  logic        wd_expired;
  logic [9:0]  oc_next;

  assign in_run = (state_q == ST_RUN);

  conv_ctrl_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk       (clk),
    .rstn      (rstn),
    .i_run     (in_run),
    .o_expired (wd_expired)
  );

  // Counts an ovalid arriving alongside conv_done; saturates on a runaway engine.
  assign oc_next = (conv_ovalid && oc_q != 10'h3FF) ? oc_q + 10'd1 : oc_q;

  always_comb begin
    state_d = state_q;
    layer_d = layer_q;
    nch_d   = nch_q;
    ch_d    = ch_q;
    w_d     = w_q;
    oc_d    = oc_q;
    win_d   = win_q;
    done_d  = 1'b0;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd.cmd_valid) begin
          layer_d = cmd.cmd_layer;
          nch_d   = cmd.cmd_nch;
          ch_d    = 8'd0;
          err_d   = 1'b0;
          if (cmd.cmd_nch == 8'd0) done_d  = 1'b1;
          else                     state_d = ST_PREF;
        end
      end
      ST_PREF: begin
        state_d = ST_RUN;
        w_d     = 5'd0;
        oc_d    = 10'd0;
        win_d   = 4'd0;
      end
      ST_RUN: begin
        if (w_q < 5'(KK))  w_d   = w_q + 5'd1;
        if (win_q != 4'hF) win_d = win_q + 4'd1;
        oc_d = oc_next;
        if (conv_done) begin
          state_d = ST_GAP;
          if (oc_next != exp_outs(layer_q)) err_d = 1'b1;
        end else if (wd_expired) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
          done_d  = 1'b1;
        end
      end
      ST_GAP: begin
        if (({1'b0, ch_q} + 9'd1) < {1'b0, nch_q}) begin
          ch_d    = ch_q + 8'd1;
          state_d = ST_PREF;
        end else begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      layer_q <= 1'b0;
      nch_q   <= 8'd0;
      ch_q    <= 8'd0;
      w_q     <= 5'd0;
      oc_q    <= 10'd0;
      win_q   <= 4'd0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      layer_q <= layer_d;
      nch_q   <= nch_d;
      ch_q    <= ch_d;
      w_q     <= w_d;
      oc_q    <= oc_d;
      win_q   <= win_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // PREF issues bit 0's address so the ROM's one-cycle latency lands it in RUN cycle 0.
  always_comb begin
    rom_addr = 13'd0;
    if (state_q == ST_PREF) rom_addr = ch_base(ch_q);
    else if (in_run)        rom_addr = ch_base(ch_q) + 13'(w_q) + ((w_q < 5'(KK)) ? 13'd1 : 13'd0);
  end

  assign cmd.cmd_ready   = (state_q == ST_IDLE);
  assign busy            = (state_q != ST_IDLE);
  assign conv_start      = in_run;
  assign win_start       = in_run && (win_q >= WOFF);
  assign conv_weight_en  = in_run && (w_q < 5'(KK));
  assign conv_weight     = conv_weight_en & rom_rdata;
  assign conv_state      = layer_q;
  assign ch_idx          = ch_q;
  assign done            = done_q;
  assign err             = err_q;

endmodule
`default_nettype wire
